sccb_init_sequencer: RTL and testbench
======================================

// Module: sccb_init_sequencer
// PURPOSE
//  Walks a register table of {reg_addr[15:0], reg_data[7:0]} entries and drives the SCCB write
//  engine, one start pulse per entry, until it reads an end marker. Bring-up and reconfiguration
//  of both OV5640 cameras go through this block. It also drives the camera-select code that
//  steers the shared SCCB bus. Table entries can be register writes or millisecond-class delays.
// PARAMETERS
//  IDX_W            8       table index width; the table holds 2**IDX_W entries
//  DELAY_UNIT_CYC   50000   clk_sys cycles per delay unit (1 ms at 50 MHz)
//  TIMEOUT_CYC      1000000 maximum clk_sys cycles spent in one SCCB wait phase
// PORTS
//  clk_sys            in   1      system clock
//  reset_n            in   1      synchronous, active-low reset
//  init_start         in   1      1-cycle pulse; starts a table walk
//  cam_sel            in   2      camera target, latched on init_start (00 both, 01 cam0, 10 cam1)
//  select_initial_cam out  2      bus steering code to the SCCB wrapper
//  tbl_index          out  IDX_W  table read index
//  tbl_entry          in   24     {addr,data}; synchronous ROM, valid 1 cycle after tbl_index changes
//  sccb_ready         in   1      write engine idle
//  sccb_start         out  1      1-cycle write request
//  sccb_address       out  16     register address, held stable from start until ready returns
//  sccb_data          out  8      register data, held stable with sccb_address
//  busy               out  1      table walk in progress
//  done               out  1      level; 1 after the end marker is reached, cleared by init_start
//  err                out  1      level; 1 after a timeout abort, cleared by init_start
//  wr_count           out  IDX_W  number of writes issued in the current or last walk
// BEHAVIOUR
//  Reset values: select_initial_cam=2'b11; tbl_index, sccb_* and wr_count = 0;
//   busy, done and err = 0; FSM in IDLE. A reset in mid-walk takes effect at the next edge.
//   sccb_start is never high in the cycle after reset.
//  Entry decode:
//   addr==16'hFFFF -> end marker
//   addr==16'hFFFE -> delay of data*DELAY_UNIT_CYC cycles (data=0 means no wait)
//   any other addr -> register write
//  IDLE:
//   on init_start: latch cam_sel, set select_initial_cam to it, clear done, err and wr_count,
//   set tbl_index=0 and busy=1, go to FETCH.
//   init_start while busy=1 is ignored.
//  FETCH (1 cycle, ROM latency) -> DECODE.
//  DECODE:
//   end marker -> DONE
//   delay -> DELAY, loading the counter
//   write -> load sccb_address and sccb_data, go to ISSUE
//  ISSUE:
//   wait for sccb_ready=1, then assert sccb_start for exactly 1 cycle, increment wr_count,
//   go to ACK_LOW.
//  ACK_LOW: wait for sccb_ready=0, then go to ACK_HIGH.
//  ACK_HIGH: wait for sccb_ready=1, then go to NEXT.
//  DELAY: count down; at zero go to NEXT.
//  NEXT:
//   if tbl_index == 2**IDX_W-1 -> DONE (the index does not wrap past the table end)
//   else tbl_index+1 and go to FETCH.
//  DONE:
//   busy=0, done=1, select_initial_cam=2'b11 (bus released), go to IDLE.
//   Outputs hold until the next init_start.
//  Minimum cycles per write: FETCH + DECODE + ISSUE + ACK_LOW + ACK_HIGH + NEXT = 6,
//   plus engine time.
//  cam_sel=2'b11 at start: the walk runs but the wrapper drives no camera.
//   It remains legal and is used for dry runs.
// CONFIGURATION
//  SCCB_SEQ_TIMEOUT_EN defined:
//   ISSUE, ACK_LOW and ACK_HIGH each share a counter of TIMEOUT_CYC cycles, reloaded on entry.
//   On expiry: go to ERROR, which sets err=1, busy=0, select_initial_cam=2'b11, then IDLE.
//   done stays 0 and wr_count holds its value.
//  SCCB_SEQ_TIMEOUT_EN undefined:
//   no counter is built; the wait states wait forever and err is tied to 0.
// TESTING
//  1. Table {0x3008,0x82},{0x3103,0x03},{0xFFFF,-}, cam_sel=01, engine model with ready low
//     for 20 cycles after each start -> two start pulses carrying those values, wr_count=2,
//     done=1, select_initial_cam=01 during the walk and 11 afterwards.
//  2. Table entry {0xFFFE,0x03} with DELAY_UNIT_CYC=10 -> 30 cycles (+/-1) between the
//     neighbouring start pulses beyond the normal per-write gap; wr_count excludes the delay.
//  3. Table holds no end marker -> walk ends after index 255 with wr_count=255 (entry 255 is a
//     write); the index must not wrap to 0.
//  4. With _EN defined and TIMEOUT_CYC=100, ready stuck low after the 3rd start -> err=1
//     about 100 cycles later, busy=0, wr_count=3, done=0.
//  5. reset_n low for 1 cycle during ACK_HIGH of write 2 -> all outputs at reset values next
//     edge; a following init_start restarts from index 0.
//  6. init_start pulsed again while busy -> ignored: no restart and cam_sel is not relatched.

Source files
------------

// File: rtl/sccb_init_sequencer_if.sv
// Bus bundle between the init sequencer, its register-table ROM and the SCCB write engine.
// master = sequencer side, slave = ROM/engine side.
interface sccb_init_sequencer_if #(
  parameter int IDX_W = 8
);
  logic [IDX_W-1:0] tbl_index;
  logic [23:0]      tbl_entry;
  logic             sccb_ready;
  logic             sccb_start;
  logic [15:0]      sccb_address;
  logic [7:0]       sccb_data;

  modport master (
    output tbl_index, sccb_start, sccb_address, sccb_data,
    input  tbl_entry, sccb_ready
  );

  modport slave (
    input  tbl_index, sccb_start, sccb_address, sccb_data,
    output tbl_entry, sccb_ready
  );
endinterface

// File: rtl/sccb_init_sequencer.sv
// SCCB init sequencer: walks a {addr,data} table, issuing one SCCB write per entry until the end marker.
// Optional wait-phase timeout abort is built only when SCCB_SEQ_TIMEOUT_EN is defined.
module sccb_init_sequencer #(
  parameter int IDX_W          = 8,
  parameter int DELAY_UNIT_CYC = 50000,
  parameter int TIMEOUT_CYC    = 1000000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  init_start,
  input  logic [1:0]            cam_sel,
  output logic [1:0]            select_initial_cam,
  sccb_init_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IDX_W-1:0]      wr_count
);

  localparam int                DLY_W    = $clog2(255 * DELAY_UNIT_CYC + 1);
  localparam logic [DLY_W-1:0]  DLY_UNIT = DLY_W'(DELAY_UNIT_CYC);
  localparam logic [DLY_W-1:0]  DLY_ONE  = DLY_W'(1);
  localparam logic [15:0]       ADDR_END = 16'hFFFF;
  localparam logic [15:0]       ADDR_DLY = 16'hFFFE;
  localparam logic [IDX_W-1:0]  IDX_LAST = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_ISSUE    = 4'd3,
    S_ACK_LOW  = 4'd4,
    S_ACK_HIGH = 4'd5,
    S_DELAY    = 4'd6,
    S_NEXT     = 4'd7,
    S_DONE     = 4'd8,
    S_ERROR    = 4'd9
  } state_t;

  state_t            state_r;
  logic [DLY_W-1:0]  dly_cnt_r;
  logic [15:0]       entry_addr_s;
  logic [7:0]        entry_data_s;

  assign entry_addr_s = bus.tbl_entry[23:8];
  assign entry_data_s = bus.tbl_entry[7:0];

`ifdef SCCB_SEQ_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             err_r;

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // Table-walk FSM; every output is a register written here.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_r            <= S_IDLE;
      select_initial_cam <= 2'b11;
      bus.tbl_index      <= '0;
      bus.sccb_start     <= 1'b0;
      bus.sccb_address   <= 16'h0000;
      bus.sccb_data      <= 8'h00;
      wr_count           <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      dly_cnt_r          <= '0;
`ifdef SCCB_SEQ_TIMEOUT_EN
      tmo_cnt_r          <= '0;
      err_r              <= 1'b0;
`endif
    end else begin
      bus.sccb_start <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (init_start) begin
            select_initial_cam <= cam_sel;
            done               <= 1'b0;
            wr_count           <= '0;
            bus.tbl_index      <= '0;
            busy               <= 1'b1;
            state_r            <= S_FETCH;
`ifdef SCCB_SEQ_TIMEOUT_EN
            err_r              <= 1'b0;
`endif
          end
        end
        S_FETCH: state_r <= S_DECODE;
        S_DECODE: begin
          if (entry_addr_s == ADDR_END) begin
            state_r <= S_DONE;
          end else if (entry_addr_s == ADDR_DLY) begin
            // Loaded with N-1 so the DELAY state lasts exactly N cycles; zero skips it.
            if (entry_data_s == 8'h00) begin
              state_r <= S_NEXT;
            end else begin
              dly_cnt_r <= DLY_W'(entry_data_s) * DLY_UNIT - DLY_ONE;
              state_r   <= S_DELAY;
            end
          end else begin
            bus.sccb_address <= entry_addr_s;
            bus.sccb_data    <= entry_data_s;
            state_r          <= S_ISSUE;
`ifdef SCCB_SEQ_TIMEOUT_EN
            tmo_cnt_r        <= TMO_LOAD;
`endif
          end
        end
        S_ISSUE: begin
          if (bus.sccb_ready) begin
            bus.sccb_start <= 1'b1;
            wr_count       <= wr_count + IDX_ONE;
            state_r        <= S_ACK_LOW;
`ifdef SCCB_SEQ_TIMEOUT_EN
            tmo_cnt_r      <= TMO_LOAD;
          end else if (tmo_cnt_r == '0) begin
            state_r   <= S_ERROR;
          end else begin
            tmo_cnt_r <= tmo_cnt_r - TMO_ONE;
`endif
          end
        end
        S_ACK_LOW: begin
          if (!bus.sccb_ready) begin
            state_r   <= S_ACK_HIGH;
`ifdef SCCB_SEQ_TIMEOUT_EN
            tmo_cnt_r <= TMO_LOAD;
          end else if (tmo_cnt_r == '0) begin
            state_r   <= S_ERROR;
          end else begin
            tmo_cnt_r <= tmo_cnt_r - TMO_ONE;
`endif
          end
        end
        S_ACK_HIGH: begin
          if (bus.sccb_ready) begin
            state_r <= S_NEXT;
`ifdef SCCB_SEQ_TIMEOUT_EN
          end else if (tmo_cnt_r == '0) begin
            state_r   <= S_ERROR;
          end else begin
            tmo_cnt_r <= tmo_cnt_r - TMO_ONE;
`endif
          end
        end
        S_DELAY: begin
          if (dly_cnt_r == '0) begin
            state_r <= S_NEXT;
          end else begin
            dly_cnt_r <= dly_cnt_r - DLY_ONE;
          end
        end
        S_NEXT: begin
          // The last table slot ends the walk rather than wrapping to index 0.
          if (bus.tbl_index == IDX_LAST) begin
            state_r <= S_DONE;
          end else begin
            bus.tbl_index <= bus.tbl_index + IDX_ONE;
            state_r       <= S_FETCH;
          end
        end
        S_DONE: begin
          busy               <= 1'b0;
          done               <= 1'b1;
          select_initial_cam <= 2'b11;
          state_r            <= S_IDLE;
        end
        S_ERROR: begin
`ifdef SCCB_SEQ_TIMEOUT_EN
          err_r              <= 1'b1;
`endif
          busy               <= 1'b0;
          select_initial_cam <= 2'b11;
          state_r            <= S_IDLE;
        end
        default: begin
          busy               <= 1'b0;
          select_initial_cam <= 2'b11;
          state_r            <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Self-checking bench for sccb_init_sequencer: randomized register tables, a behavioural SCCB engine
// and a table-level reference model of which writes a walk must issue.
`timescale 1ns/1ps
module tb_sccb_init_sequencer;
  localparam int IDX_W = 8;
  localparam int DUC   = 10;
  localparam int TMO   = 100;
  localparam int DEPTH = 256;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic             init_start = 1'b0;
  logic [1:0]       cam_sel = 2'b00;
  logic [1:0]       select_initial_cam;
  logic             busy, done, err;
  logic [IDX_W-1:0] wr_count;

  int checks = 0;
  int failures = 0;

  sccb_init_sequencer_if #(.IDX_W(IDX_W)) bus ();

  sccb_init_sequencer #(.IDX_W(IDX_W), .DELAY_UNIT_CYC(DUC), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .init_start(init_start), .cam_sel(cam_sel),
    .select_initial_cam(select_initial_cam), .bus(bus.master),
    .busy(busy), .done(done), .err(err), .wr_count(wr_count)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous table ROM
  logic [23:0] rom [DEPTH];
  always @(posedge clk_sys) bus.tbl_entry <= rom[bus.tbl_index];

  // SCCB write engine: ready drops for eng_lat cycles after each accepted start, or forever once hung
  int          eng_lat = 4;
  int          eng_hang_at = 0;
  int          eng_cnt = 0;
  int          eng_starts = 0;
  int          eng_unstable = 0;
  bit          eng_hung = 1'b0;
  bit          eng_rst = 1'b1;
  logic [23:0] eng_hold = 24'h0;
  always @(posedge clk_sys) begin
    if (eng_rst) begin
      bus.sccb_ready <= 1'b1;
      eng_cnt        <= 0;
      eng_hung       <= 1'b0;
    end else if (bus.sccb_ready !== 1'b1) begin
      if (reset_n && {bus.sccb_address, bus.sccb_data} !== eng_hold) eng_unstable <= eng_unstable + 1;
      if (!eng_hung) begin
        if (eng_cnt <= 1) bus.sccb_ready <= 1'b1;
        else eng_cnt <= eng_cnt - 1;
      end
    end else if (bus.sccb_start === 1'b1) begin
      bus.sccb_ready <= 1'b0;
      eng_cnt        <= eng_lat;
      eng_hold       <= {bus.sccb_address, bus.sccb_data};
      eng_starts     <= eng_starts + 1;
      if (eng_hang_at != 0 && eng_starts + 1 == eng_hang_at) eng_hung <= 1'b1;
    end
  end

  // Start-pulse monitor, sampled on the falling edge
  logic [23:0] mon_w [$];
  logic [1:0]  mon_sel [$];
  longint      mon_cyc [$];
  longint      cyc = 0;
  int          mon_dbl = 0;
  bit          prev_start = 1'b0;
  always @(negedge clk_sys) begin
    cyc <= cyc + 1;
    if (bus.sccb_start === 1'b1) begin
      mon_w.push_back({bus.sccb_address, bus.sccb_data});
      mon_sel.push_back(select_initial_cam);
      mon_cyc.push_back(cyc);
      if (prev_start) mon_dbl <= mon_dbl + 1;
    end
    prev_start <= (bus.sccb_start === 1'b1);
  end

  // Reference model: walk the table, collect writes until end marker or table end
  function automatic void model_walk(output logic [23:0] w[$]);
    w.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i][23:8] == 16'hFFFF) break;
      if (rom[i][23:8] != 16'hFFFE) w.push_back(rom[i]);
    end
  endfunction

  function automatic logic [23:0] rand_write();
    return {16'($urandom_range(0, 65533)), 8'($urandom)};
  endfunction

  task automatic fill_junk();
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_write();
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0; eng_rst = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1; eng_rst = 1'b0;
  endtask

  task automatic start_walk(input logic [1:0] cam);
    @(negedge clk_sys);
    cam_sel = cam; init_start = 1'b1;
    @(negedge clk_sys);
    init_start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit to);
    int n;
    n = 0; to = 1'b0;
    while (busy !== 1'b0) begin
      if (n >= bound) begin to = 1'b1; break; end
      @(negedge clk_sys); n++;
    end
  endtask

  task automatic wait_starts(input int base, input int want, input int bound, output bit to);
    int n;
    n = 0; to = 1'b0;
    while (mon_w.size() - base < want) begin
      if (n >= bound) begin to = 1'b1; break; end
      @(negedge clk_sys); n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_sys);
    checks++;
    if ({select_initial_cam, bus.tbl_index, bus.sccb_start, bus.sccb_address, bus.sccb_data,
         busy, done, err, wr_count} !== {2'b11, 8'd0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_values got sel=%b idx=%0d st=%b a=%h d=%h busy=%b done=%b err=%b wc=%0d exp sel=11 rest 0",
               select_initial_cam, bus.tbl_index, bus.sccb_start, bus.sccb_address, bus.sccb_data,
               busy, done, err, wr_count);
    end
  endtask

  task automatic test_basic();
    logic [23:0] exp_w [$];
    int base, ndbl, nuns;
    bit to;
    fill_junk();
    rom[0] = {16'h3008, 8'h82}; rom[1] = {16'h3103, 8'h03}; rom[2] = {16'hFFFF, 8'h00};
    eng_lat = 20; base = mon_w.size(); ndbl = mon_dbl; nuns = eng_unstable;
    model_walk(exp_w);
    start_walk(2'b01);
    wait_idle(2000, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout busy still %b after 2000 cycles, exp 0", busy); end
    checks++;
    if (mon_w.size() - base != exp_w.size()) begin
      failures++; $display("FAIL basic_count got=%0d exp=%0d", mon_w.size() - base, exp_w.size());
    end else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        checks++;
        if (mon_w[base+i] !== exp_w[i] || mon_sel[base+i] !== 2'b01) begin
          failures++; $display("FAIL basic_write%0d got=%h sel=%b exp=%h sel=01", i, mon_w[base+i], mon_sel[base+i], exp_w[i]);
        end
      end
    end
    checks++;
    if ({wr_count, done, busy, err, select_initial_cam} !== {8'd2, 1'b1, 1'b0, 1'b0, 2'b11}) begin
      failures++; $display("FAIL basic_final got wc=%0d done=%b busy=%b err=%b sel=%b exp wc=2 done=1 busy=0 err=0 sel=11",
                           wr_count, done, busy, err, select_initial_cam);
    end
    checks++;
    if (mon_dbl != ndbl || eng_unstable != nuns) begin
      failures++; $display("FAIL basic_handshake got dbl=%0d unstable=%0d exp 0 0", mon_dbl - ndbl, eng_unstable - nuns);
    end
  endtask

  task automatic test_random();
    logic [23:0] exp_w [$];
    logic [1:0]  cam;
    int base, n, errs;
    bit to;
    for (int it = 0; it < 6; it++) begin
      fill_junk();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        if ($urandom_range(0, 4) == 0) rom[i] = {16'hFFFE, 8'($urandom_range(0, 2))};
        else rom[i] = rand_write();
      rom[n] = {16'hFFFF, 8'($urandom)};
      cam = 2'($urandom_range(0, 3)); eng_lat = $urandom_range(1, 6); base = mon_w.size();
      model_walk(exp_w);
      start_walk(cam);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL rand%0d_start got done=%b busy=%b exp done=0 busy=1", it, done, busy);
      end
      wait_idle(2000, to);
      errs = 0;
      if (mon_w.size() - base != exp_w.size()) errs++;
      else for (int i = 0; i < exp_w.size(); i++) if (mon_w[base+i] !== exp_w[i] || mon_sel[base+i] !== cam) errs++;
      checks++;
      if (to || errs != 0) begin
        failures++; $display("FAIL rand%0d_writes got n=%0d bad=%0d to=%b exp n=%0d bad=0", it, mon_w.size() - base, errs, to, exp_w.size());
      end
      checks++;
      if ({wr_count, done, err, select_initial_cam} !== {8'(exp_w.size()), 1'b1, 1'b0, 2'b11}) begin
        failures++; $display("FAIL rand%0d_final got wc=%0d done=%b err=%b sel=%b exp wc=%0d done=1 err=0 sel=11",
                             it, wr_count, done, err, select_initial_cam, exp_w.size());
      end
    end
  endtask

  task automatic test_delay();
    longint gap [2];
    int d, base, diff;
    bit to;
    d = $urandom_range(1, 6); eng_lat = 3;
    for (int k = 0; k < 2; k++) begin
      fill_junk();
      rom[0] = rand_write(); rom[1] = {16'hFFFE, (k == 0) ? 8'h00 : 8'(d)};
      rom[2] = rand_write(); rom[3] = {16'hFFFF, 8'h00};
      base = mon_w.size();
      start_walk(2'b10);
      wait_idle(2000, to);
      gap[k] = (mon_w.size() - base >= 2) ? mon_cyc[base+1] - mon_cyc[base] : 0;
      checks++;
      if (to || mon_w.size() - base != 2 || wr_count !== 8'd2) begin
        failures++; $display("FAIL delay%0d_count got n=%0d wc=%0d to=%b exp n=2 wc=2", k, mon_w.size() - base, wr_count, to);
      end
    end
    diff = int'(gap[1] - gap[0]) - d * DUC;
    checks++;
    if (diff < -1 || diff > 1) begin
      failures++; $display("FAIL delay_gap got extra=%0d exp=%0d (+/-1)", gap[1] - gap[0], d * DUC);
    end
  endtask

  task automatic test_no_marker();
    int base;
    bit to;
    rom[0] = {16'hFFFE, 8'h00};
    for (int i = 1; i < DEPTH; i++) rom[i] = rand_write();
    eng_lat = 1; base = mon_w.size();
    start_walk(2'b00);
    wait_idle(20000, to);
    checks++;
    if (to || mon_w.size() - base != 255) begin
      failures++; $display("FAIL nomark_count got n=%0d to=%b exp n=255", mon_w.size() - base, to);
    end
    checks++;
    if ({wr_count, done, bus.tbl_index} !== {8'd255, 1'b1, 8'd255}) begin
      failures++; $display("FAIL nomark_final got wc=%0d done=%b idx=%0d exp wc=255 done=1 idx=255", wr_count, done, bus.tbl_index);
    end
    checks++;
    if (mon_w.size() - base == 255 && (mon_w[base] !== rom[1] || mon_w[base+254] !== rom[255])) begin
      failures++; $display("FAIL nomark_ends got first=%h last=%h exp first=%h last=%h", mon_w[base], mon_w[base+254], rom[1], rom[255]);
    end
  endtask

  task automatic test_timeout();
    int base;
    bit to;
    fill_junk();
    for (int i = 0; i < 6; i++) rom[i] = rand_write();
    rom[6] = {16'hFFFF, 8'h00};
    eng_lat = 5; base = mon_w.size();
`ifdef SCCB_SEQ_TIMEOUT_EN
    begin
      longint t_err;
      int n;
      eng_hang_at = eng_starts + 3;
      start_walk(2'b01);
      n = 0;
      while (err !== 1'b1 && n < 1000) begin @(negedge clk_sys); n++; end
      t_err = cyc;
      checks++;
      if (err !== 1'b1 || mon_w.size() - base != 3) begin
        failures++; $display("FAIL tmo_err got err=%b n=%0d exp err=1 n=3", err, mon_w.size() - base);
      end else begin
        checks++;
        if (t_err - mon_cyc[base+2] < 95 || t_err - mon_cyc[base+2] > 110) begin
          failures++; $display("FAIL tmo_latency got=%0d exp=95..110", t_err - mon_cyc[base+2]);
        end
      end
      checks++;
      if ({busy, done, wr_count, select_initial_cam} !== {1'b0, 1'b0, 8'd3, 2'b11}) begin
        failures++; $display("FAIL tmo_final got busy=%b done=%b wc=%0d sel=%b exp busy=0 done=0 wc=3 sel=11",
                             busy, done, wr_count, select_initial_cam);
      end
      eng_hang_at = 0;
      @(negedge clk_sys); eng_rst = 1'b1; @(negedge clk_sys); eng_rst = 1'b0;
      start_walk(2'b01);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL tmo_clear got err=%b exp 0", err); end
      wait_idle(2000, to);
    end
`else
    eng_hang_at = eng_starts + 1;
    start_walk(2'b01);
    repeat (300) @(negedge clk_sys);
    checks++;
    if ({err, busy, done} !== {1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL hang_wait got err=%b busy=%b done=%b exp err=0 busy=1 done=0", err, busy, done);
    end
    eng_hang_at = 0;
    do_reset();
`endif
  endtask

  task automatic test_reset_mid();
    logic [23:0] exp_w [$];
    int base;
    bit to;
    fill_junk();
    for (int i = 0; i < 4; i++) rom[i] = rand_write();
    rom[4] = {16'hFFFF, 8'h00};
    model_walk(exp_w);
    eng_lat = 20; base = mon_w.size();
    start_walk(2'b10);
    wait_starts(base, 2, 500, to);
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (to || {select_initial_cam, bus.tbl_index, bus.sccb_start, bus.sccb_address, bus.sccb_data,
               busy, done, err, wr_count} !== {2'b11, 8'd0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL midreset_values got sel=%b idx=%0d st=%b a=%h busy=%b done=%b wc=%0d to=%b exp sel=11 rest 0",
               select_initial_cam, bus.tbl_index, bus.sccb_start, bus.sccb_address, busy, done, wr_count, to);
    end
    reset_n = 1'b1;
    repeat (30) @(negedge clk_sys);
    base = mon_w.size();
    start_walk(2'b01);
    wait_idle(2000, to);
    checks++;
    if (to || mon_w.size() - base != 4 || mon_w[base] !== exp_w[0] || wr_count !== 8'd4 || done !== 1'b1) begin
      failures++; $display("FAIL midreset_restart got n=%0d first=%h wc=%0d done=%b exp n=4 first=%h wc=4 done=1",
                           mon_w.size() - base, (mon_w.size() > base) ? mon_w[base] : 24'h0, wr_count, done, exp_w[0]);
    end
  endtask

  task automatic test_ignore_restart();
    logic [23:0] exp_w [$];
    int base, errs;
    bit to;
    fill_junk();
    for (int i = 0; i < 4; i++) rom[i] = rand_write();
    rom[4] = {16'hFFFF, 8'h00};
    model_walk(exp_w);
    eng_lat = 10; base = mon_w.size();
    start_walk(2'b10);
    wait_starts(base, 1, 500, to);
    start_walk(2'b01);
    wait_idle(2000, to);
    errs = 0;
    if (mon_w.size() - base != 4) errs++;
    else for (int i = 0; i < 4; i++) if (mon_w[base+i] !== exp_w[i] || mon_sel[base+i] !== 2'b10) errs++;
    checks++;
    if (to || errs != 0 || wr_count !== 8'd4) begin
      failures++; $display("FAIL ignore_restart got n=%0d bad=%0d wc=%0d exp n=4 bad=0 wc=4 sel=10", mon_w.size() - base, errs, wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_delay();
    test_no_marker();
    test_timeout();
    test_reset_mid();
    test_ignore_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
